// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded-instruction inputs, forwarding taps from the
// EX/MEM and MEM/WB pipeline registers, and the EX-side operand/control outputs.
// The slave modport is the id_ex_stage view. The master modport is the view of
// whatever surrounds it: the decode stage, the later pipeline stages, or a bench.
interface id_ex_if #(
  parameter int DW = 32
);
  logic          id_valid;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic [4:0]    id_rd;
  logic [DW-1:0] id_rs_val;
  logic [DW-1:0] id_rt_val;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic [3:0]    id_alu_control;
  logic          id_alusrc;
  logic          id_shsrc;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic          flush;

  logic          exmem_regwrite;
  logic [4:0]    exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [4:0]    memwb_rd;
  logic [DW-1:0] memwb_result;

  logic          stall_id;
  logic          ex_valid;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_control;
  logic [DW-1:0] ex_store_data;
  logic [4:0]    ex_rd;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_val, id_rt_val, id_imm,
           id_shamt, id_alu_control, id_alusrc, id_shsrc, id_regwrite,
           id_memread, id_memwrite, flush,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output stall_id, ex_valid, alu_a, alu_b, alu_control, ex_store_data,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_val, id_rt_val, id_imm,
           id_shamt, id_alu_control, id_alusrc, id_shsrc, id_regwrite,
           id_memread, id_memwrite, flush,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  stall_id, ex_valid, alu_a, alu_b, alu_control, ex_store_data,
           ex_rd, ex_regwrite, ex_memread, ex_memwrite
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and operand forwarding.
// The stage registers the decoded instruction and builds the ALU operands
// combinationally in EX. It raises stall_id to hold IF/ID when an operand is
// not yet available.
// Configuration macro ID_EX_FORWARD_EN:
//   defined   - EX/MEM and MEM/WB results are forwarded. Only a load-use
//               dependency stalls, for one cycle.
//   undefined - operands come from the register file only. A dependency on a
//               writer in EX or EX/MEM stalls until the writer reaches MEM/WB.
//               The register file writes before it is read, so MEM/WB needs
//               no stall.
module id_ex_stage #(
  parameter int DW = 32
) (
  input logic    clk,
  input logic    rst_n,
  id_ex_if.slave bus
);

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Register 0 is hard-wired to zero, so it never matches a producer.
  function automatic logic src_match(input logic       wr,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
    return wr && (dst != 5'd0) && (dst == src);
  endfunction

  // The youngest producer wins: EX/MEM is newer than MEM/WB.
  function automatic logic [DW-1:0] fwd_operand(input logic [4:0]    src,
                                                input logic [DW-1:0] reg_val,
                                                input logic          exmem_wr,
                                                input logic [4:0]    exmem_dst,
                                                input logic [DW-1:0] exmem_val,
                                                input logic          memwb_wr,
                                                input logic [4:0]    memwb_dst,
                                                input logic [DW-1:0] memwb_val);
    if (src_match(exmem_wr, exmem_dst, src)) return exmem_val;
    if (src_match(memwb_wr, memwb_dst, src)) return memwb_val;
    return reg_val;
  endfunction

  logic          vld_p1;
  logic [4:0]    rs_p1, rt_p1, rd_p1, shamt_p1;
  logic [DW-1:0] rs_val_p1, rt_val_p1, imm_p1;
  logic [3:0]    alu_control_p1;
  logic          alusrc_p1, shsrc_p1;
  logic          regwrite_p1, memread_p1, memwrite_p1;

  logic          load_use, ex_dep, exmem_dep, hazard, stall, capture;
  logic [DW-1:0] rs_fwd, rt_fwd;

  // Hazard detection on the ID instruction. Flush overrides the stall.
  always_comb begin
    load_use  = src_match(vld_p1 & memread_p1, rd_p1, bus.id_rs) |
                src_match(vld_p1 & memread_p1, rd_p1, bus.id_rt);
    ex_dep    = src_match(vld_p1 & regwrite_p1, rd_p1, bus.id_rs) |
                src_match(vld_p1 & regwrite_p1, rd_p1, bus.id_rt);
    exmem_dep = src_match(bus.exmem_regwrite, bus.exmem_rd, bus.id_rs) |
                src_match(bus.exmem_regwrite, bus.exmem_rd, bus.id_rt);
    hazard    = FWD_EN ? load_use : (load_use | ex_dep | exmem_dep);
    stall     = bus.id_valid & ~bus.flush & hazard;
    capture   = bus.id_valid & ~bus.flush & ~stall;
  end

  // ---- ID -> EX boundary (p1) ----
  // Capture a real instruction, or load a bubble by clearing valid and the
  // memory/writeback controls. Operand data is left unchanged on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1         <= 1'b0;
      regwrite_p1    <= 1'b0;
      memread_p1     <= 1'b0;
      memwrite_p1    <= 1'b0;
      rs_p1          <= '0;
      rt_p1          <= '0;
      rd_p1          <= '0;
      shamt_p1       <= '0;
      rs_val_p1      <= '0;
      rt_val_p1      <= '0;
      imm_p1         <= '0;
      alu_control_p1 <= '0;
      alusrc_p1      <= 1'b0;
      shsrc_p1       <= 1'b0;
    end else begin
      vld_p1      <= capture;
      regwrite_p1 <= capture & bus.id_regwrite;
      memread_p1  <= capture & bus.id_memread;
      memwrite_p1 <= capture & bus.id_memwrite;
      if (capture) begin
        rs_p1          <= bus.id_rs;
        rt_p1          <= bus.id_rt;
        rd_p1          <= bus.id_rd;
        shamt_p1       <= bus.id_shamt;
        rs_val_p1      <= bus.id_rs_val;
        rt_val_p1      <= bus.id_rt_val;
        imm_p1         <= bus.id_imm;
        alu_control_p1 <= bus.id_alu_control;
        alusrc_p1      <= bus.id_alusrc;
        shsrc_p1       <= bus.id_shsrc;
      end
    end
  end

  // EX operand selection from registered state plus the forwarding taps.
  always_comb begin
    rs_fwd = FWD_EN ? fwd_operand(rs_p1, rs_val_p1,
                                  bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                                  bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result)
                    : rs_val_p1;
    rt_fwd = FWD_EN ? fwd_operand(rt_p1, rt_val_p1,
                                  bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                                  bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result)
                    : rt_val_p1;
  end

  assign bus.alu_a         = shsrc_p1 ? {{(DW-5){1'b0}}, shamt_p1} : rs_fwd;
  assign bus.alu_b         = alusrc_p1 ? imm_p1 : rt_fwd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.alu_control   = alu_control_p1;
  assign bus.ex_rd         = rd_p1;
  assign bus.ex_valid      = vld_p1;
  assign bus.ex_regwrite   = vld_p1 & regwrite_p1;
  assign bus.ex_memread    = vld_p1 & memread_p1;
  assign bus.ex_memwrite   = vld_p1 & memwrite_p1;
  assign bus.stall_id      = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. It runs small instruction programs through a
// program-order architectural model. The model keeps an architectural register
// file that is updated at issue, and a physical register file that is written
// at writeback. It also tracks the EX, MEM and WB pipeline slots, which supply
// the forwarding taps. Every issued instruction pushes its expected EX view
// into a scoreboard, and the monitor pops it when the DUT shows ex_valid.
module tb_id_ex_stage;

  typedef struct {
    bit          v;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic [3:0]  alu;
    bit          alusrc, shsrc, rw, mr, mw;
    logic [31:0] res;
  } instr_t;

  typedef struct {
    logic [31:0] a, b, st;
    logic [4:0]  rd;
    logic [3:0]  alu;
    bit          rw, mr, mw;
  } exp_t;

  logic clk;
  logic rst_n;

  id_ex_if #(.DW(32)) bus ();
  id_ex_stage #(.DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          dut_stalls = 0;
  instr_t      ex_s, mem_s, wb_s, cur;
  bit          exp_stall;
  logic [31:0] rf[32];
  logic [31:0] arch[32];
  instr_t      prog[$];
  exp_t        sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t t;
    t = '{v: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, shamt: 5'd0, imm: 32'd0, alu: 4'd0,
          alusrc: 1'b0, shsrc: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, res: 32'd0};
    return t;
  endfunction

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [4:0] shamt,
                                input logic [3:0] alu, input bit alusrc, input bit shsrc,
                                input bit rw, input bit mr, input bit mw);
    instr_t t;
    t = '{v: 1'b1, rs: rs, rt: rt, rd: rd, shamt: shamt, imm: imm, alu: alu,
          alusrc: alusrc, shsrc: shsrc, rw: rw, mr: mr, mw: mw, res: 32'd0};
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int     k;
    k = $urandom_range(0, 9);
    t = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 5)),
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t.v = ($urandom_range(0, 4) != 0);
    if (k == 4 || k == 5) t.alusrc = 1'b1;
    else if (k == 6) t.shsrc = 1'b1;
    else if (k == 7 || k == 8) begin t.alusrc = 1'b1; t.mr = 1'b1; t.alu = 4'd0; end
    else if (k == 9) begin t.alusrc = 1'b1; t.mw = 1'b1; t.rw = 1'b0; t.alu = 4'd0; end
    return t;
  endfunction

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return b << a[4:0];
      default: return a + b;
    endcase
  endfunction

  // A slot holds a value the ID instruction is waiting for.
  function automatic bit depends(input instr_t s, input instr_t id);
    return s.v && s.rd != 5'd0 && (s.rd == id.rs || s.rd == id.rt);
  endfunction

  task automatic drive(input bit fl);
    if (wb_s.v && wb_s.rw && wb_s.rd != 5'd0) rf[wb_s.rd] = wb_s.res;
    cur = (prog.size() != 0) ? prog[0] : bubble();
    bus.id_valid       = cur.v;
    bus.id_rs          = cur.rs;
    bus.id_rt          = cur.rt;
    bus.id_rd          = cur.rd;
    bus.id_rs_val      = rf[cur.rs];
    bus.id_rt_val      = rf[cur.rt];
    bus.id_imm         = cur.imm;
    bus.id_shamt       = cur.shamt;
    bus.id_alu_control = cur.alu;
    bus.id_alusrc      = cur.alusrc;
    bus.id_shsrc       = cur.shsrc;
    bus.id_regwrite    = cur.rw;
    bus.id_memread     = cur.mr;
    bus.id_memwrite    = cur.mw;
    bus.flush          = fl;
    bus.exmem_regwrite = mem_s.v && mem_s.rw;
    bus.exmem_rd       = mem_s.v ? mem_s.rd : 5'($urandom);
    bus.exmem_result   = (mem_s.v && !mem_s.mr) ? mem_s.res : $urandom;
    bus.memwb_regwrite = wb_s.v && wb_s.rw;
    bus.memwb_rd       = wb_s.v ? wb_s.rd : 5'($urandom);
    bus.memwb_result   = wb_s.v ? wb_s.res : $urandom;
`ifdef ID_EX_FORWARD_EN
    exp_stall = cur.v && !fl && depends(ex_s, cur) && ex_s.mr;
`else
    exp_stall = cur.v && !fl && ((depends(ex_s, cur) && (ex_s.rw || ex_s.mr)) ||
                                 (depends(mem_s, cur) && mem_s.rw));
`endif
  endtask

  task automatic advance(input bit fl);
    instr_t nx;
    exp_t   e;
    nx = bubble();
    if (cur.v && !exp_stall && !fl) begin
      e.a   = cur.shsrc ? {27'd0, cur.shamt} : arch[cur.rs];
      e.b   = cur.alusrc ? cur.imm : arch[cur.rt];
      e.st  = arch[cur.rt];
      e.rd  = cur.rd;
      e.alu = cur.alu;
      e.rw  = cur.rw;
      e.mr  = cur.mr;
      e.mw  = cur.mw;
      nx     = cur;
      nx.res = cur.mr ? $urandom : alu_fn(cur.alu, e.a, e.b);
      if (cur.rw && cur.rd != 5'd0) arch[cur.rd] = nx.res;
      sbq.push_back(e);
    end
    if (prog.size() != 0 && (!cur.v || fl || !exp_stall)) void'(prog.pop_front());
    wb_s  = mem_s;
    mem_s = ex_s;
    ex_s  = nx;
  endtask

  task automatic cycle(input bit fl);
    drive(fl);
    @(negedge clk);
    check("stall_id", 32'(bus.stall_id), 32'(exp_stall));
    if (bus.stall_id) dut_stalls++;
    @(posedge clk);
    advance(fl);
    #1;
  endtask

  task automatic run_prog();
    int n;
    n = 0;
    while (prog.size() != 0 && n < 60) begin
      cycle(1'b0);
      n++;
    end
    if (prog.size() != 0) begin
      check("prog_budget", 32'(prog.size()), 32'd0);
      prog.delete();
    end
    repeat (3) cycle(1'b0);
  endtask

  task automatic seq_check(input string name, input int exp_stalls);
    dut_stalls = 0;
    run_prog();
    check(name, 32'(dut_stalls), 32'(exp_stalls));
  endtask

  // Scoreboard monitor: every valid EX slot must match the next issued
  // instruction. A bubble must keep all memory/writeback controls low.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.ex_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL ex_unexpected: got ex_valid=1 want no pending issue");
        end else begin
          e = sbq.pop_front();
          if ({bus.alu_a, bus.alu_b, bus.ex_store_data, bus.ex_rd, bus.alu_control,
               bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite} !==
              {e.a, e.b, e.st, e.rd, e.alu, e.rw, e.mr, e.mw}) begin
            errors++;
            $display("FAIL ex_issue: got a=%h b=%h st=%h rd=%0d op=%0d rw/mr/mw=%b%b%b want a=%h b=%h st=%h rd=%0d op=%0d rw/mr/mw=%b%b%b",
                     bus.alu_a, bus.alu_b, bus.ex_store_data, bus.ex_rd, bus.alu_control,
                     bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                     e.a, e.b, e.st, e.rd, e.alu, e.rw, e.mr, e.mw);
          end
        end
      end else begin
        checks++;
        if ({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite} !== 3'b000) begin
          errors++;
          $display("FAIL bubble_gating: got rw/mr/mw=%b%b%b want 000",
                   bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    for (int i = 0; i < 32; i++) arch[i] = rf[i];
    ex_s = bubble(); mem_s = bubble(); wb_s = bubble();
    rst_n = 1'b0;
    drive(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_stall", 32'(bus.stall_id), 32'd0);
    check("rst_ctrl", 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}), 32'd0);
    check("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
    check("rst_alu_control", 32'(bus.alu_control), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back dependent ALU ops.
    prog.push_back(mk(5'd0, 5'd0, 5'd3, 32'h10, 5'd0, 4'd0, 1, 0, 1, 0, 0));
    prog.push_back(mk(5'd3, 5'd5, 5'd4, 32'h0, 5'd0, 4'd1, 0, 0, 1, 0, 0));
`ifdef ID_EX_FORWARD_EN
    seq_check("add_sub_stalls", 0);
`else
    seq_check("add_sub_stalls", 2);
`endif

    // Two older writers of $3: the younger (0x11) must win.
    prog.push_back(mk(5'd0, 5'd0, 5'd3, 32'h22, 5'd0, 4'd0, 1, 0, 1, 0, 0));
    prog.push_back(mk(5'd0, 5'd0, 5'd3, 32'h11, 5'd0, 4'd0, 1, 0, 1, 0, 0));
    prog.push_back(mk(5'd3, 5'd0, 5'd7, 32'h0, 5'd0, 4'd0, 0, 0, 1, 0, 0));
`ifdef ID_EX_FORWARD_EN
    seq_check("prio_stalls", 0);
`else
    seq_check("prio_stalls", 2);
`endif

    // Load-use dependency.
    prog.push_back(mk(5'd1, 5'd0, 5'd2, 32'h40, 5'd0, 4'd0, 1, 0, 1, 1, 0));
    prog.push_back(mk(5'd2, 5'd1, 5'd8, 32'h0, 5'd0, 4'd0, 0, 0, 1, 0, 0));
`ifdef ID_EX_FORWARD_EN
    seq_check("load_use_stalls", 1);
`else
    seq_check("load_use_stalls", 2);
`endif

    // A write to $0 must be neither forwarded nor treated as a hazard.
    prog.push_back(mk(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 5'd0, 4'd0, 1, 0, 1, 0, 0));
    prog.push_back(mk(5'd0, 5'd0, 5'd9, 32'h0, 5'd0, 4'd0, 0, 0, 1, 0, 0));
    seq_check("r0_stalls", 0);

    // Flush while a load-use hazard is pending.
    prog.push_back(mk(5'd1, 5'd0, 5'd2, 32'h44, 5'd0, 4'd0, 1, 0, 1, 1, 0));
    prog.push_back(mk(5'd2, 5'd2, 5'd6, 32'h0, 5'd0, 4'd0, 0, 0, 1, 0, 0));
    cycle(1'b0);
    cycle(1'b1);
    check("flush_bubble", 32'(bus.ex_valid), 32'd0);
    run_prog();

    // Reset asserted in the middle of a load-use stall.
    prog.push_back(mk(5'd1, 5'd0, 5'd2, 32'h48, 5'd0, 4'd0, 1, 0, 1, 1, 0));
    prog.push_back(mk(5'd2, 5'd1, 5'd10, 32'h0, 5'd0, 4'd0, 0, 0, 1, 0, 0));
    cycle(1'b0);
    drive(1'b0);
    @(negedge clk);
    check("pre_rst_stall", 32'(bus.stall_id), 32'(exp_stall));
    check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
    check("mid_rst_stall", 32'(bus.stall_id), 32'd0);
    check("mid_rst_ctrl", 32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}), 32'd0);
    check("mid_rst_ex_rd", 32'(bus.ex_rd), 32'd0);
    check("mid_rst_alu_a", bus.alu_a, 32'd0);
    check("mid_rst_alu_b", bus.alu_b, 32'd0);
    prog.delete();
    sbq.delete();
    ex_s = bubble(); mem_s = bubble(); wb_s = bubble();
    for (int i = 0; i < 32; i++) arch[i] = rf[i];
    drive(1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prog.push_back(mk(5'd2, 5'd1, 5'd10, 32'h0, 5'd0, 4'd0, 0, 0, 1, 0, 0));
    seq_check("post_rst_stalls", 0);

    // Random programs with occasional flushes and idle ID slots.
    repeat (600) begin
      if (prog.size() == 0) prog.push_back(rand_instr());
      cycle($urandom_range(0, 15) == 0);
    end
    run_prog();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
